seg7_scan_scheduler: RTL
========================

// Module: seg7_scan_scheduler
// PURPOSE
//   Time-multiplexes an 8-digit common-anode 7-segment display from one 32-bit hex value.
//   Owns the scan sequencing: digit-slot timing, per-digit enable, PWM brightness and
//   frame-aligned double-buffered updates via a valid/ready load port.
//   Sits between client logic and the existing seven_segment decoder: digit -> decoder -> CA..CG.
// PARAMETERS
//   CLK_HZ    100_000_000  input clock frequency
//   SCAN_HZ   1000         digit-slot rate; one frame = 8 slots
//   SUB_DIV   CLK_HZ/(SCAN_HZ*8)  clocks per PWM phase (derived localparam, must be >= 1)
// PORTS
//   CLK100MHZ   in   1   system clock
//   RST         in   1   synchronous reset, active-high
//   load_valid  in   1   client presents new display value
//   load_data   in   32  8 hex nibbles; [3:0] = digit 0 (rightmost, AN[0])
//   load_ready  out  1   shadow buffer empty; load accepted when load_valid & load_ready
//   digit_en    in   8   per-digit enable; 0 = slot blanked
//   dp_mask     in   8   per-digit decimal point; 1 = lit
//   bright      in   3   on-phases per slot minus 1 (0 = 1/8 duty, 7 = full)
//   AN          out  8   anode selects, active-low, at most one low
//   digit       out  4   nibble for the active slot (to seven_segment)
//   DP          out  1   decimal point, active-low
//   frame_done  out  1   1-cycle pulse at the slot 7 -> slot 0 wrap
// BEHAVIOUR
//   - Reset: AN=8'hFF, digit=0, DP=1, frame_done=0, load_ready=1, active value=0,
//     shadow empty, slot=0, phase=0, prescaler=0. RST mid-frame aborts the frame; no pulse.
//   - Prescaler counts 0..SUB_DIV-1; terminal count = phase tick. Phase 0..7 advances per
//     tick; phase 7 -> 0 advances slot 0..7; slot 7 -> 0 (with phase 7 -> 0) = frame boundary.
//   - Per cycle: lit = digit_en[slot] & (phase <= bright). AN[slot]=~lit, others 1.
//     digit = active[4*slot +: 4]; DP = ~(dp_mask[slot] & lit). Outputs registered:
//     reflect state one cycle later. digit_en/dp_mask/bright are sampled live each cycle.
//   - Blanked slot still consumes its full slot time (constant frame rate, uniform duty).
//   - Load: on valid&ready, load_data -> shadow, shadow_full=1, load_ready=0 next cycle.
//     At frame boundary, if shadow_full: active <= shadow, shadow_full=0, load_ready=1
//     next cycle. Accept coinciding with boundary (shadow was empty): data waits in shadow
//     until the following boundary. Active value never changes mid-frame (no tearing).
//   - frame_done asserts the cycle after the boundary, regardless of pending load.
//   - load_data held by client only while valid & ~ready; no other handshake rules.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: slots above the most significant nonzero nibble of the
//     active value are blanked (as if digit_en bit = 0); slot 0 is never zero-blanked;
//     mask recomputed only when active value updates.
//   Not defined: all enabled digits shown, including leading zeros.
// STRUCTURE
//   Shared package seg7_pkg: N_DIGITS=8, N_PHASES=8, AN_ALL_OFF=8'hFF, nibble typedef.
//   Sub-module scan_tick_gen (prescaler, parameter SUB_DIV, outputs 1-cycle tick).
//   Slot/phase counters, double buffer and output regs live in this module.
// TESTING (CLK_HZ=800, SCAN_HZ=10 -> SUB_DIV=10, slot=80 clk, frame=640 clk)
//   1. RST held 3 cycles -> AN=FF, DP=1, digit=0, load_ready=1, frame_done=0.
//   2. load 32'h12345678, bright=7, en=FF -> after boundary slot0 AN=FE digit=8 80 clk,
//      slot1 AN=FD digit=7, ... slot7 AN=7F digit=1; frame_done every 640 clk.
//   3. bright=1 -> AN[slot] low 20 clk then high 60 clk each slot; bright=0 -> 10 clk low.
//   4. two back-to-back loads A then B -> B stalls (ready=0) until boundary shows A; B
//      shown one frame later; no mid-frame value change.
//   5. digit_en=0F, dp_mask=01 -> AN stays FF in slots 4-7; DP=0 only in slot 0.
//   6. RST asserted mid-slot 3 -> next cycle all reset values; scan restarts at slot 0.
//   7. (LEADING_ZERO_BLANK_EN) value 32'h00000340 -> slots 3-7 blank; 32'h0 -> slot 0 shows 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 8-digit 7-segment scan scheduler.
package seg7_pkg;

   localparam int N_DIGITS = 8;
   localparam int N_PHASES = 8;
   localparam logic [7:0] AN_ALL_OFF = 8'hFF;

   typedef logic [3:0] nibble_t;

   // Visible-digit mask for leading-zero blanking: every slot up to the most
   // significant nonzero nibble is visible, and slot 0 always is.
   function automatic logic [7:0] lz_mask(input logic [31:0] value);
      logic [7:0] mask;
      logic seen;
      mask = '0;
      seen = 1'b0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         if (value[4*i +: 4] != 4'h0) seen = 1'b1;
         mask[i] = seen | (i == 0);
      end
      return mask;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler for the scan scheduler: counts 0..SUB_DIV-1 and flags the terminal count
// as a one-cycle tick that advances the PWM phase.
module scan_tick_gen #(
   parameter int SUB_DIV = 10
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(SUB_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == TC) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == TC);

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Scan scheduler for an 8-digit common-anode display: slot/phase sequencing, PWM
// brightness and frame-aligned double buffering. Optional LEADING_ZERO_BLANK_EN.
module seg7_scan_scheduler
   import seg7_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCAN_HZ = 1000
) (
   input  logic        CLK100MHZ,
   input  logic        RST,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   output logic        load_ready,
   input  logic [7:0]  digit_en,
   input  logic [7:0]  dp_mask,
   input  logic [2:0]  bright,
   output logic [7:0]  AN,
   output logic [3:0]  digit,
   output logic        DP,
   output logic        frame_done
);

   localparam int SUB_DIV = CLK_HZ / (SCAN_HZ * N_DIGITS);
   localparam logic [2:0] LAST_PHASE = 3'(N_PHASES - 1);
   localparam logic [2:0] LAST_SLOT  = 3'(N_DIGITS - 1);

   logic        tick;
   logic        boundary;
   logic        accept;
   logic        lit;
   logic [7:0]  vis;

   logic [2:0]  slot_q, slot_d;
   logic [2:0]  phase_q, phase_d;
   logic [31:0] active_q, active_d;
   logic [31:0] shadow_q, shadow_d;
   logic        shadow_full_q, shadow_full_d;
   logic [7:0]  an_q, an_d;
   nibble_t     digit_q, digit_d;
   logic        dp_q, dp_d;
   logic        frame_done_q, frame_done_d;

   scan_tick_gen #(.SUB_DIV(SUB_DIV)) u_tick (
      .clk  (CLK100MHZ),
      .rst  (RST),
      .tick (tick)
   );

   assign boundary = tick & (phase_q == LAST_PHASE) & (slot_q == LAST_SLOT);
   assign accept   = load_valid & ~shadow_full_q;

`ifdef LEADING_ZERO_BLANK_EN
   logic [7:0] vis_q, vis_d;

   always_comb begin
      vis_d = vis_q;
      if (!accept && boundary && shadow_full_q) vis_d = lz_mask(shadow_q);
   end

   // Reset active value is zero, which shows only slot 0.
   always_ff @(posedge CLK100MHZ) begin
      if (RST) vis_q <= 8'h01;
      else     vis_q <= vis_d;
   end

   assign vis = vis_q;
`else
   assign vis = 8'hFF;
`endif

   always_comb begin
      phase_d = phase_q;
      slot_d  = slot_q;
      if (tick) begin
         phase_d = phase_q + 3'd1;
         if (phase_q == LAST_PHASE) slot_d = slot_q + 3'd1;
      end

      // Accept and swap are exclusive: accept needs an empty shadow, swap a full one.
      shadow_d      = shadow_q;
      shadow_full_d = shadow_full_q;
      active_d      = active_q;
      if (accept) begin
         shadow_d      = load_data;
         shadow_full_d = 1'b1;
      end else if (boundary && shadow_full_q) begin
         active_d      = shadow_q;
         shadow_full_d = 1'b0;
      end

      lit = digit_en[slot_q] & vis[slot_q] & (phase_q <= bright);
      an_d = AN_ALL_OFF;
      if (lit) an_d[slot_q] = 1'b0;
      digit_d      = active_q[{slot_q, 2'b00} +: 4];
      dp_d         = ~(dp_mask[slot_q] & lit);
      frame_done_d = boundary;
   end

   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         slot_q        <= '0;
         phase_q       <= '0;
         active_q      <= '0;
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         an_q          <= AN_ALL_OFF;
         digit_q       <= '0;
         dp_q          <= 1'b1;
         frame_done_q  <= 1'b0;
      end else begin
         slot_q        <= slot_d;
         phase_q       <= phase_d;
         active_q      <= active_d;
         shadow_q      <= shadow_d;
         shadow_full_q <= shadow_full_d;
         an_q          <= an_d;
         digit_q       <= digit_d;
         dp_q          <= dp_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign load_ready = ~shadow_full_q;
   assign AN         = an_q;
   assign digit      = digit_q;
   assign DP         = dp_q;
   assign frame_done = frame_done_q;

endmodule
